// File: rtl/fir_acc.sv
// fir_acc -- accumulate-and-dump stage of a time-multiplexed FIR filter.
//
// Sums TAPS signed products from an upstream multiplier into one wide
// accumulator, then rounds (half-up), shifts out SHIFT fractional bits,
// saturates to OUT_W bits and presents the sample on a valid/ready output.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   prod_i     in   24-bit signed product
//   prod_valid in   prod_i valid this cycle
//   prod_ready out  block accepts prod_i this cycle
//   out_data   out  OUT_W-bit signed filtered sample
//   out_sat    out  out_data was clipped (qualified by out_valid)
//   out_valid  out  out_data / out_sat valid
//   out_ready  in   downstream accepts out_data this cycle
module fir_acc #(
    parameter int TAPS  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      prod_i,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PROD_W = 24;
    localparam int CNT_W  = $clog2(TAPS);
    localparam int ACC_W  = PROD_W + CNT_W;
    // Rounding needs one guard bit above the accumulator; also keep the
    // working width above OUT_W so the saturation limits are representable.
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;

    localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic signed [EXT_W-1:0] HALF     = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX  =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN  =
        {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [CNT_W-1:0]          cnt;
    logic signed [ACC_W-1:0]   acc_p0;
    logic signed [ACC_W-1:0]   prod_ext_p0;
    logic signed [ACC_W-1:0]   sum_p0;
    logic                      accept;
    logic                      last_tap;
    logic [OUT_W:0]            res_p1;

    // Round half-up and drop SHIFT fractional bits: floor((s + 2^(SHIFT-1)) / 2^SHIFT).
    function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
        logic signed [EXT_W-1:0] wide;
        wide = {{(EXT_W - ACC_W){s[ACC_W-1]}}, s};
        wide = wide + HALF;
        return wide >>> SHIFT;
    endfunction

    // Clip to the OUT_W signed range; result is {clipped_flag, sample}.
    function automatic logic [OUT_W:0] saturate(input logic signed [EXT_W-1:0] r);
        logic [OUT_W:0] res;
        if (r > SAT_MAX) begin
            res = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (r < SAT_MIN) begin
            res = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, r[OUT_W-1:0]};
        end
        return res;
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next-state logic (TAPS >= 2, so the first tap is never the last)
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = ACCUM;
            ACCUM:   if (last_tap) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs and handshake qualifiers. Only the last tap can stall,
    // and only when the previous result is still waiting downstream.
    // prod_valid deliberately does not feed prod_ready.
    always_comb begin
        prod_ready = 1'b1;
        if (cnt == LAST_TAP && out_valid && !out_ready) begin
            prod_ready = 1'b0;
        end
        accept   = prod_valid && prod_ready;
        last_tap = accept && (cnt == LAST_TAP);
    end

    // stage 0: sign-extend and accumulate; IDLE starts a fresh sum
    always_comb begin
        prod_ext_p0 = {{CNT_W{prod_i[PROD_W-1]}}, prod_i};
        if (state == IDLE) begin
            sum_p0 = prod_ext_p0;
        end else begin
            sum_p0 = acc_p0 + prod_ext_p0;
        end
        res_p1 = saturate(round_shift(sum_p0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc_p0 <= '0;
        end else if (accept) begin
            acc_p0 <= sum_p0;
            if (last_tap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // stage 1: output register; a new result may load in the same cycle
    // the old one drains, keeping out_valid high without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (last_tap) begin
            out_data  <= res_p1[OUT_W-1:0];
            out_sat   <= res_p1[OUT_W];
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/fir_acc.md
FIR_ACC -- requirements
Module: fir_acc

Interface
REQ-001 SHALL have parameter TAPS, default 16, number of products summed per output sample (power of two, 2..64).
REQ-002 SHALL have parameter OUT_W, default 16, output sample width.
REQ-003 SHALL have parameter SHIFT, default 9, fractional bits removed from the accumulator (coefficient Q-format), SHIFT >= 1.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port prod_i, input, 24, signed two's-complement product from the upstream multiplier.
REQ-007 SHALL have port prod_valid, input, 1, prod_i is valid this cycle.
REQ-008 SHALL have port prod_ready, output, 1, block accepts prod_i this cycle.
REQ-009 SHALL have port out_data, output, OUT_W, signed filtered sample.
REQ-010 SHALL have port out_sat, output, 1, out_data was clipped; qualified by out_valid.
REQ-011 SHALL have port out_valid, output, 1, out_data/out_sat valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data this cycle.

Function
REQ-013 SHALL accept a product on a cycle with prod_valid=1 and prod_ready=1, and on no other cycle.
REQ-014 SHALL hold an internal signed accumulator of ACC_W = 24 + log2(TAPS) bits, with all products sign-extended to ACC_W, so no internal overflow is possible.
REQ-015 SHALL keep a tap counter 0..TAPS-1; FSM states IDLE (counter=0, no partial sum) and ACCUM (counter>0).
REQ-016 SHALL, on acceptance in IDLE, load the accumulator with the sign-extended product (no dependency on the previous sum), set the counter to 1, and go to ACCUM.
REQ-017 SHALL, on acceptance in ACCUM with counter < TAPS-1, add the product and increment the counter.
REQ-018 SHALL treat acceptance at counter = TAPS-1 as the last tap: compute the full sum S = acc + prod, set the counter to 0, return to IDLE, and load the output register in the same cycle.
REQ-019 SHALL compute the output as R = floor((S + 2^(SHIFT-1)) / 2^SHIFT), i.e. round-half-up with an arithmetic shift.
REQ-020 SHALL saturate R to [-2^(OUT_W-1), 2^(OUT_W-1)-1], set out_sat=1 if clipped, and set out_sat=0 otherwise.
REQ-021 SHALL assert out_valid the cycle after the last-tap acceptance (latency 1 from last product to output).
REQ-022 SHALL hold out_data, out_sat and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid after a cycle with out_valid=1 and out_ready=1, unless a new result loads in that same cycle, in which case out_valid stays 1 with the new data (no bubble, no loss).
REQ-024 SHALL drive prod_ready=0 only when counter = TAPS-1, out_valid=1 and out_ready=0, and drive prod_ready=1 otherwise (non-last taps are never stalled).
REQ-025 SHALL leave state unchanged on cycles with no acceptance, apart from the output drain described in REQ-023.
REQ-026 SHALL derive prod_ready combinationally from the counter, out_valid and out_ready only, never from prod_valid.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set the accumulator to 0, the counter to 0 (IDLE), out_data to 0, out_sat to 0 and out_valid to 0, discarding any partial frame.
REQ-028 SHALL give rst priority over any simultaneous product acceptance or output handshake.
REQ-029 SHALL drive prod_ready=1 in the cycle following reset release.

Verification (TAPS=4, OUT_W=16, SHIFT=9)
REQ-030 SHALL be verified: products 512,512,512,512 with out_ready=1 -> out_data=4, out_sat=0, out_valid for 1 cycle, one cycle after the 4th product.
REQ-031 SHALL be verified: products -512 x4 -> out_data=-4 (0xFFFC); products 256,0,0,0 -> out_data=1; products 255,0,0,0 -> out_data=0.
REQ-032 SHALL be verified: products 0x7FFFFF x4 -> out_data=32767, out_sat=1; products 0x800000 x4 -> out_data=-32768, out_sat=1.
REQ-033 SHALL be verified: out_ready=0 with one result pending, 4 new products offered back-to-back -> taps 1-3 accepted, prod_ready=0 at tap 4 until out_ready=1; in that cycle the old result drains, the new one loads, and out_valid stays 1.
REQ-034 SHALL be verified: rst pulsed after 2 accepted products, then products 512 x4 -> out_data=4 (no residue from the aborted frame), out_valid=0 during and after reset until then.
REQ-035 SHALL be verified: prod_valid toggled randomly over 100 frames against a reference model -> all outputs match, in order, none dropped or duplicated.
